// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: FSM states, store-buffer entry
// layout, access-size encodings and the byte-lane mask helper.
package lsu_pkg;

   localparam int LSU_ADDR_W = 32;
   localparam int LSU_DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      LD_ADDR,
      LD_DATA,
      ST_ADDR,
      ST_DATA
   } lsu_state_t;

   typedef struct packed {
      logic [LSU_ADDR_W-1:0] addr;
      logic [1:0]            size;
      logic [LSU_DATA_W-1:0] wdata;
      logic [3:0]            mask;
   } sb_entry_t;

   // Addresses are pre-checked for alignment, so a half only sits at offset 0 or 2.
   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SZ_BYTE: return 4'b0001 << offset;
         SZ_HALF: return 4'b0011 << offset;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_store_fifo.sv
// Posted-store buffer: circular entry array with wrap-bit pointers, head view,
// and a per-entry overlap vector against a probe word address and byte mask.
module lsu_store_fifo
   import lsu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  sb_entry_t             push_entry,
   input  logic [LSU_ADDR_W-3:0] probe_word,
   input  logic [3:0]            probe_mask,
   output logic                  full,
   output logic                  empty,
   output logic [LSU_ADDR_W-1:0] head_addr,
   output logic [1:0]            head_size,
   output logic [LSU_DATA_W-1:0] head_wdata,
   output logic [DEPTH-1:0]      conflict
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] count;
   sb_entry_t     entries [DEPTH];

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the entry array has no reset; clearing the pointers already marks every slot dead.
   always_ff @(posedge clk) begin
      if (push) entries[wr_ptr[IW-1:0]] <= push_entry;
   end

   assign head_addr  = entries[rd_ptr[IW-1:0]].addr;
   assign head_size  = entries[rd_ptr[IW-1:0]].size;
   assign head_wdata = entries[rd_ptr[IW-1:0]].wdata;

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      logic [IW-1:0] offset;
      // NOTE: every always_comb output gets a default first so no latch can be inferred.
      conflict = '0;
      offset   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset      = IW'(i) - rd_ptr[IW-1:0];
         conflict[i] = ({1'b0, offset} < count)
                    && (entries[i].addr[LSU_ADDR_W-1:2] == probe_word)
                    && ((entries[i].mask & probe_mask) != 4'b0000);
      end
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: posted stores, load bypass past non-overlapping
// buffered stores, and a single-outstanding SRAM-like bus sequencer.
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int SB_DEPTH = 4,
   parameter int ADDR_W   = LSU_ADDR_W,
   parameter int DATA_W   = LSU_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_wr,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              exc_flush,
   output logic              lsu_stall,
   output logic              ld_valid,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              sb_empty,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata
);

   lsu_state_t          state;
   logic                kill;
   logic                sb_full;
   logic                sb_none;
   logic [ADDR_W-1:0]   head_addr;
   logic [1:0]          head_size;
   logic [DATA_W-1:0]   head_wdata;
   logic [SB_DEPTH-1:0] conflict;
   logic [3:0]          req_mask;
   sb_entry_t           req_entry;
   logic                store_acc;
   logic                load_go;
   logic                sb_pop;

   assign req_mask  = byte_mask(req_size, req_addr[1:0]);
   assign req_entry = '{addr: req_addr, size: req_size, wdata: req_wdata, mask: req_mask};

   // A flush in the same cycle cancels the store rather than letting it post.
   assign store_acc = req_valid && req_wr && !sb_full && !exc_flush;
   assign load_go   = req_valid && !req_wr && (conflict == '0) && !exc_flush;
   assign sb_pop    = (state == ST_DATA) && data_data_ok;

   assign ld_valid  = (state == LD_DATA) && data_data_ok && !kill && !exc_flush;
   assign ld_rdata  = data_rdata;
   assign lsu_stall = req_valid && !store_acc && !ld_valid;
   assign sb_empty  = sb_none;

   lsu_store_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (store_acc),
      .pop        (sb_pop),
      .push_entry (req_entry),
      .probe_word (req_addr[ADDR_W-1:2]),
      .probe_mask (req_mask),
      .full       (sb_full),
      .empty      (sb_none),
      .head_addr  (head_addr),
      .head_size  (head_size),
      .head_wdata (head_wdata),
      .conflict   (conflict)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         kill       <= 1'b0;
         data_req   <= 1'b0;
         data_wr    <= 1'b0;
         data_size  <= '0;
         data_addr  <= '0;
         data_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_go) begin
                  state      <= LD_ADDR;
                  data_req   <= 1'b1;
                  data_wr    <= 1'b0;
                  data_size  <= req_size;
                  data_addr  <= req_addr;
                  data_wdata <= '0;
               end else if (!sb_none) begin
                  state      <= ST_ADDR;
                  data_req   <= 1'b1;
                  data_wr    <= 1'b1;
                  data_size  <= head_size;
                  data_addr  <= head_addr;
                  data_wdata <= head_wdata;
               end else if (store_acc) begin
                  // Empty buffer: the incoming store becomes the head, so issue it directly.
                  state      <= ST_ADDR;
                  data_req   <= 1'b1;
                  data_wr    <= 1'b1;
                  data_size  <= req_size;
                  data_addr  <= req_addr;
                  data_wdata <= req_wdata;
               end
            end
            LD_ADDR: begin
               if (data_addr_ok) begin
                  state    <= LD_DATA;
                  data_req <= 1'b0;
                  kill     <= exc_flush;
               end else if (exc_flush) begin
                  state    <= IDLE;
                  data_req <= 1'b0;
               end
            end
            LD_DATA: begin
               if (data_data_ok) begin
                  state <= IDLE;
                  kill  <= 1'b0;
               end else if (exc_flush) begin
                  kill <= 1'b1;
               end
            end
            ST_ADDR: begin
               if (data_addr_ok) begin
                  state    <= ST_DATA;
                  data_req <= 1'b0;
               end
            end
            ST_DATA: begin
               if (data_data_ok) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
